// File: rtl/time_pkg.sv
// Shared time-of-day definitions for the time keeper and the alarm stage.
// Declarations only: no latency, no flow control.
package time_pkg;

  typedef enum logic [2:0] {
    FLD_SEC   = 3'd0,
    FLD_SEC10 = 3'd1,
    FLD_MIN   = 3'd2,
    FLD_MIN10 = 3'd3,
    FLD_HR    = 3'd4,
    FLD_HR10  = 3'd5
  } field_e;

  // MSB-first declaration so the packed layout matches the 19-bit present_time bus.
  typedef struct packed {
    logic       hour10;
    logic [3:0] hour;
    logic [2:0] min10;
    logic [3:0] min;
    logic [2:0] sec10;
    logic [3:0] sec;
  } tod_t;

  localparam int TIME_W    = 19;
  localparam int SEC_LSB   = 0;
  localparam int SEC_W     = 4;
  localparam int SEC10_LSB = 4;
  localparam int SEC10_W   = 3;
  localparam int MIN_LSB   = 7;
  localparam int MIN_W     = 4;
  localparam int MIN10_LSB = 11;
  localparam int MIN10_W   = 3;
  localparam int HR_LSB    = 14;
  localparam int HR_W      = 4;
  localparam int HR10_LSB  = 18;
  localparam int HR10_W    = 1;

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_TSET = 2'b01;
  localparam logic [1:0] ST_ASET = 2'b10;

  localparam logic [3:0] SEC_MAX = 4'd9;
  localparam logic [2:0] TEN_MAX = 3'd5;
  localparam logic [4:0] HR_WRAP = 5'd11;

  function automatic logic [4:0] hour_val(input tod_t t);
    return (t.hour10 ? 5'd10 : 5'd0) + {1'b0, t.hour};
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Raw pushbutton to one-cycle event: 2-flop synchroniser then rising-edge detect.
// Latency: event acts on the 3rd edge after the raw rise; a held button gives one event; no backpressure.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign evt = sync_q & ~prev_q;

endmodule

// File: rtl/time_keeper.sv
// 12-hour BCD time-of-day counter with a pushbutton time-set mode feeding the alarm stage.
// Latency: time updates one edge after a tick or button event; no backpressure (buttons are events).
import time_pkg::*;

module time_keeper #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  STATE,
  input  logic        btn_sel,
  input  logic        btn_inc,
  output logic [18:0] present_time,
  output logic [2:0]  set_field,
  output logic        tick_1hz
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  tod_t          tod_q, tod_d;
  field_e        fld_q, fld_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sel_evt;
  logic          inc_evt;
  logic          set_mode;
  logic          tick;

  btn_edge u_sel (.clk(clk), .rst(rst), .btn(btn_sel), .evt(sel_evt));
  btn_edge u_inc (.clk(clk), .rst(rst), .btn(btn_inc), .evt(inc_evt));

  // Increment field f by one and ripple the carry through every field above it.
  function automatic tod_t incr(input tod_t t, input field_e f);
    tod_t n;
    logic c;
    n = t;
    c = (f == FLD_SEC);
    if (c) begin
      if (n.sec == SEC_MAX) n.sec = 4'd0;
      else begin n.sec = n.sec + 4'd1; c = 1'b0; end
    end
    c = c | (f == FLD_SEC10);
    if (c) begin
      if (n.sec10 == TEN_MAX) n.sec10 = 3'd0;
      else begin n.sec10 = n.sec10 + 3'd1; c = 1'b0; end
    end
    c = c | (f == FLD_MIN);
    if (c) begin
      if (n.min == SEC_MAX) n.min = 4'd0;
      else begin n.min = n.min + 4'd1; c = 1'b0; end
    end
    c = c | (f == FLD_MIN10);
    if (c) begin
      if (n.min10 == TEN_MAX) n.min10 = 3'd0;
      else begin n.min10 = n.min10 + 3'd1; c = 1'b0; end
    end
    c = c | (f == FLD_HR);
    if (c) begin
      if (hour_val(n) == HR_WRAP) begin
        n.hour   = 4'd0;
        n.hour10 = 1'b0;
      end else if (n.hour == SEC_MAX) begin
        n.hour   = 4'd0;
        n.hour10 = 1'b1;
      end else begin
        n.hour = n.hour + 4'd1;
      end
    end
    // Toggling into the tens keeps the hour legal by dropping units above 1.
    if (f == FLD_HR10) begin
      n.hour10 = ~n.hour10;
      if (n.hour10 && (n.hour > 4'd1)) n.hour = 4'd0;
    end
    return n;
  endfunction

  assign set_mode = (STATE == ST_TSET);
  assign tick     = !set_mode && (presc_q == PRESC_LAST);

  always_comb begin
    tod_d   = tod_q;
    fld_d   = fld_q;
    presc_d = presc_q;
    if (set_mode) begin
      presc_d = '0;
      if (inc_evt) tod_d = incr(tod_q, fld_q);
      if (sel_evt) fld_d = (fld_q == FLD_HR10) ? FLD_SEC : field_e'(fld_q + 3'd1);
    end else if (tick) begin
      presc_d = '0;
      tod_d   = incr(tod_q, FLD_SEC);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tod_q   <= '0;
      fld_q   <= FLD_SEC;
      presc_q <= '0;
    end else begin
      tod_q   <= tod_d;
      fld_q   <= fld_d;
      presc_q <= presc_d;
    end
  end

  assign present_time = tod_q;
  assign set_field    = fld_q;
  assign tick_1hz     = tick;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: table of set-mode increments, hand corner sequences, random run/set mix.
module tb_time_keeper;

  localparam int TD  = 4;
  localparam int DAY = 43200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  STATE = 2'b00;
  logic        btn_sel = 1'b0;
  logic        btn_inc = 1'b0;
  logic [18:0] present_time;
  logic [2:0]  set_field;
  logic        tick_1hz;

  int checks = 0;
  int errors = 0;
  int msecs  = 0;
  int mfld   = 0;

  typedef struct {
    int          start_s;
    int          fld;
    logic [18:0] exp;
  } vec_t;

  vec_t vt[12];

  time_keeper #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .STATE(STATE), .btn_sel(btn_sel), .btn_inc(btn_inc),
    .present_time(present_time), .set_field(set_field), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [18:0] pack(input int h10, h, m10, m, s10, s);
    return {1'(h10), 4'(h), 3'(m10), 4'(m), 3'(s10), 4'(s)};
  endfunction

  function automatic logic [18:0] to_bus(input int s);
    int h, m, sc;
    h  = s / 3600;
    m  = (s / 60) % 60;
    sc = s % 60;
    return pack(h / 10, h % 10, m / 10, m % 10, sc / 10, sc % 10);
  endfunction

  // Field increment as time arithmetic on seconds-of-day; hour10 is a +/-10 hour toggle.
  function automatic int inc_secs(input int s, input int f);
    int h;
    case (f)
      0: return (s + 1) % DAY;
      1: return (s + 10) % DAY;
      2: return (s + 60) % DAY;
      3: return (s + 600) % DAY;
      4: return (s + 3600) % DAY;
      default: begin
        h = s / 3600;
        if (h >= 10) return s - 36000;
        if (h >= 2) return s - h * 3600 + 36000;
        return s + 36000;
      end
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; btn_sel = 1'b0; btn_inc = 1'b0; STATE = 2'b01;
    cyc();
    cyc();
    rst = 1'b0; msecs = 0; mfld = 0;
  endtask

  task automatic press(input bit s, input bit i, input int hold);
    btn_sel = s; btn_inc = i;
    repeat (hold) begin
      cyc();
      chk("set_no_tick", 32'(tick_1hz), 0);
    end
    btn_sel = 1'b0; btn_inc = 1'b0;
    repeat (4) cyc();
    if (i) msecs = inc_secs(msecs, mfld);
    if (s) mfld = (mfld + 1) % 6;
    chk("press_time", 32'(present_time), 32'(to_bus(msecs)));
    chk("press_field", 32'(set_field), 32'(mfld));
  endtask

  task automatic navigate(input int f);
    for (int k = 0; k < 6 && mfld != f; k++) press(1'b1, 1'b0, 1);
  endtask

  task automatic preload(input int s);
    int h, m, sc;
    h = s / 3600; m = (s / 60) % 60; sc = s % 60;
    do_reset();
    repeat (5) press(1'b1, 1'b0, 1);
    if (h >= 10) press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1);
    repeat (sc % 10) press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1);
    repeat (sc / 10) press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1);
    repeat (m % 10) press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1);
    repeat (m / 10) press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1);
    repeat (h % 10) press(1'b0, 1'b1, 1);
    chk("preload", 32'(present_time), 32'(to_bus(s)));
  endtask

  // Enter run mode from set mode; ticks land every TD cycles counted from entry.
  task automatic run_phase(input int n, input logic [1:0] st, input bit poke);
    STATE = st;
    for (int i = 1; i <= n; i++) begin
      cyc();
      if (i % TD == 0) msecs = (msecs + 1) % DAY;
      chk("run_tick", 32'(tick_1hz), 32'(i % TD == TD - 1));
      chk("run_time", 32'(present_time), 32'(to_bus(msecs)));
      chk("run_field", 32'(set_field), 32'(mfld));
      if (poke && i == 1) begin btn_sel = 1'b1; btn_inc = 1'b1; end
      if (i == 2) begin btn_sel = 1'b0; btn_inc = 1'b0; end
    end
    STATE = 2'b01;
    cyc();
    chk("exit_run_tick", 32'(tick_1hz), 0);
    chk("exit_run_time", 32'(present_time), 32'(to_bus(msecs)));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] run_codes [3];
    run_codes[0] = 2'b00; run_codes[1] = 2'b10; run_codes[2] = 2'b11;

    vt[0]  = '{9*3600 + 59*60 + 59,  0, pack(1, 0, 0, 0, 0, 0)};
    vt[1]  = '{9,                    0, pack(0, 0, 0, 0, 1, 0)};
    vt[2]  = '{57,                   1, pack(0, 0, 0, 1, 0, 7)};
    vt[3]  = '{9*60 + 30,            2, pack(0, 0, 1, 0, 3, 0)};
    vt[4]  = '{59*60,                3, pack(0, 1, 0, 9, 0, 0)};
    vt[5]  = '{11*3600 + 30*60,      4, pack(0, 0, 3, 0, 0, 0)};
    vt[6]  = '{5*3600,               5, pack(1, 0, 0, 0, 0, 0)};
    vt[7]  = '{1*3600,               5, pack(1, 1, 0, 0, 0, 0)};
    vt[8]  = '{11*3600 + 12*60 + 13, 5, pack(0, 1, 1, 2, 1, 3)};
    vt[9]  = '{3*3600 + 27*60 + 14,  2, pack(0, 3, 2, 8, 1, 4)};
    vt[10] = '{11*3600 + 59*60 + 59, 0, pack(0, 0, 0, 0, 0, 0)};
    vt[11] = '{8*3600 + 5*60,        4, pack(0, 9, 0, 5, 0, 0)};

    // Reset state.
    rst = 1'b1; STATE = 2'b00;
    cyc();
    cyc();
    chk("reset_time", 32'(present_time), 0);
    chk("reset_field", 32'(set_field), 0);
    chk("reset_tick", 32'(tick_1hz), 0);

    // Free run from reset: ten ticks give 00:00:10.
    do_reset();
    run_phase(40, 2'b00, 1'b0);
    chk("run40", 32'(present_time), 32'(pack(0, 0, 0, 0, 1, 0)));

    // Midnight wrap.
    preload(11*3600 + 59*60 + 58);
    run_phase(4, 2'b00, 1'b0);
    chk("wrap_1", 32'(present_time), 32'(pack(1, 1, 5, 9, 5, 9)));
    run_phase(4, 2'b00, 1'b0);
    chk("wrap_2", 32'(present_time), 0);

    for (int v = 0; v < 12; v++) begin
      preload(vt[v].start_s);
      navigate(vt[v].fld);
      press(1'b0, 1'b1, 1);
      chk($sformatf("vec%0d", v), 32'(present_time), 32'(vt[v].exp));
    end

    // Field selection cycle and a long held press.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      press(1'b1, 1'b0, 1);
      chk("sel_cycle", 32'(set_field), 32'((k + 1) % 6));
    end
    press(1'b1, 1'b0, 100);
    chk("sel_held", 32'(set_field), 1);
    repeat (20) begin
      cyc();
      chk("set_idle_tick", 32'(tick_1hz), 0);
    end

    // Reset on the tick cycle in run mode.
    preload(3*3600 + 27*60 + 14);
    navigate(2);
    STATE = 2'b00;
    repeat (3) cyc();
    chk("pre_rst_tick", 32'(tick_1hz), 1);
    rst = 1'b1;
    cyc();
    chk("rst_run_time", 32'(present_time), 0);
    chk("rst_run_field", 32'(set_field), 0);
    chk("rst_run_tick", 32'(tick_1hz), 0);
    STATE = 2'b01; rst = 1'b0; msecs = 0; mfld = 0;

    // Reset coinciding with an increment event in set mode.
    preload(3*3600 + 27*60 + 14);
    navigate(2);
    btn_inc = 1'b1;
    cyc();
    cyc();
    rst = 1'b1; btn_inc = 1'b0;
    cyc();
    chk("rst_inc_time", 32'(present_time), 0);
    chk("rst_inc_field", 32'(set_field), 0);
    chk("rst_inc_tick", 32'(tick_1hz), 0);
    rst = 1'b0; msecs = 0; mfld = 0;
    repeat (4) cyc();
    chk("rst_inc_quiet", 32'(present_time), 0);

    // Random mix of run phases and button presses against the model.
    do_reset();
    repeat (40) begin
      bit s, i;
      if ($urandom_range(0, 2) == 0) begin
        run_phase(int'($urandom_range(8, 24)), run_codes[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
      end else begin
        s = 1'($urandom_range(0, 1));
        i = s ? 1'($urandom_range(0, 1)) : 1'b1;
        press(s, i, int'($urandom_range(1, 6)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Upstream of the alarm stage: keeps the running time of day and drives the 19-bit packed present_time bus that the alarm comparator consumes.
- Counts seconds from a divided system clock, with 12-hour wrap (00:00:00 to 11:59:59).
- Provides a time-set mode in which pushbuttons select a digit field and increment it, with carry into higher fields.

Parameters:
- TICK_DIV, 50000000: clk cycles per 1 s tick; minimum 2; benches use 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- STATE  in  2  global mode; 2'b01 = time-set, any other value = run.
- btn_sel  in  1  raw field-select pushbutton, asynchronous level.
- btn_inc  in  1  raw increment pushbutton, asynchronous level.
- present_time  out  19  packed time: [3:0] sec, [6:4] sec10, [10:7] min, [13:11] min10, [17:14] hour, [18] hour10.
- set_field  out  3  selected field; 0=sec, 1=sec10, 2=min, 3=min10, 4=hour, 5=hour10.
- tick_1hz  out  1  one-cycle pulse on each counted second.

Behaviour:
- Reset values: all time digits 0 (present_time = 19'h0), set_field = 0, tick_1hz = 0, prescaler = 0, button synchronisers and edge detectors = 0.
- Button inputs:
  - Each goes through a 2-flop synchroniser, then a rising-edge detector.
  - An edge is usable 3 cycles after the raw rise.
  - A held button produces exactly one event.
- Run mode (STATE != 2'b01):
  - Prescaler counts 0 to TICK_DIV-1, then wraps to 0.
  - On the wrap cycle, tick_1hz = 1 for one cycle and time advances by 1 s in that same clock edge.
  - present_time is registered; it changes on the cycle after the tick's prescaler wrap edge.
- Carry chain:
  - sec 9 to 0, carry to sec10.
  - sec10 5 to 0, carry to min.
  - min 9 to 0, carry to min10.
  - min10 5 to 0, carry to hour.
  - hour 9 to 0 with hour10 becoming 1.
  - hour10=1 and hour=1 rolls to hour 0, hour10 0; 11:59:59 becomes 00:00:00.
- Set mode (STATE == 2'b01):
  - Prescaler held at 0, tick_1hz = 0, no time advance.
  - btn_sel event: set_field increments; 5 wraps to 0.
  - btn_inc event: the selected field increments with the full carry chain from that field upward.
  - sec10 increments 5 to 0 and carries to min; min10 likewise carries to hour.
  - Field 5 toggles hour10. When it toggles 0 to 1 with hour > 1, hour is forced to 0, so the result is never above 11.
- Simultaneous btn_sel and btn_inc events in the same cycle: the increment applies to the old set_field, and set_field advances in the same cycle.
- Button events in run mode are ignored; set_field holds its value.
- On leaving set mode, the prescaler starts from 0, so the first tick occurs TICK_DIV cycles later.
- On entering set mode, an in-progress prescaler count is discarded.
- rst mid-operation clears everything on the next edge and overrides all buttons and ticks.
- Invariant: present_time always holds legal BCD within 00:00:00 to 11:59:59.

Decomposition:
- Shared package time_pkg:
  - field encodings FLD_SEC..FLD_HR10.
  - packed bit offsets and widths for the 19-bit time bus.
  - STATE encodings ST_RUN and ST_TSET (2'b01), plus the alarm-set code 2'b10 used by the alarm stage.
  - limit constants SEC_MAX=9, TEN_MAX=5, HR_WRAP (11).
- The alarm stage imports the same package.
- Sub-module btn_edge: 2-flop synchroniser plus rising-edge detector, instantiated twice.
- The carry chain stays inline as one combinational next-time function.

Test Plan (TICK_DIV=4):
- Reset, then run 40 cycles → tick_1hz pulses every 4 cycles; present_time sec goes 1..9, 0 with sec10=1 after 10 ticks.
- Preload 11:59:58 via set mode, return to run, wait 2 ticks → 11:59:59, then 00:00:00 (present_time=19'h0).
- Set mode, field 0 at sec=9 sec10=5 min=9 min10=5 hour=9, one btn_inc → 10:00:00 (hour10=1, lower digits 0).
- Set mode, btn_sel pressed 6 times → set_field goes 1,2,3,4,5,0; a 100-cycle held press counts once.
- Set mode, hour=5 hour10=0, field 5, btn_inc → hour10=1, hour=0; no tick_1hz during 20 cycles in set mode.
- Assert rst mid-count at 03:27:14 together with a btn_inc edge → next cycle present_time=0, set_field=0, tick_1hz=0.
